serial_div: RTL and testbench
=============================

SERIAL_DIV -- requirements
Module: serial_div

Interface
REQ-001 Parameter WIDTH, default 8, operand and quotient width in bits.
REQ-002 Parameter FRAC, default 0, fractional bits of the quotient; quotient = floor((x << FRAC) / y).
REQ-003 Clocking: one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is asyn_reset.
REQ-004 Port clk, input, 1 bit, rising-edge clock.
REQ-005 Port asyn_reset, input, 1 bit, asynchronous active-high reset.
REQ-006 Port x, input, WIDTH bits, unsigned dividend.
REQ-007 Port y, input, WIDTH bits, unsigned divisor.
REQ-008 Port quotient, output, WIDTH bits, result.
REQ-009 Port data_x_vld, input, 1 bit, x valid.
REQ-010 Port data_x_rdy, output, 1 bit, x may be accepted.
REQ-011 Port data_y_vld, input, 1 bit, y valid.
REQ-012 Port data_y_rdy, output, 1 bit, y may be accepted.
REQ-013 Port d_out_vld, output, 1 bit, quotient valid.
REQ-014 Port d_out_rdy, input, 1 bit, consumer accepts quotient.
REQ-015 Port order is x, y, quotient, clk, asyn_reset, data_x_vld, data_x_rdy, data_y_vld, data_y_rdy, d_out_vld, d_out_rdy.

Function
REQ-016 The FSM has three states: IDLE, CALC and DONE.
REQ-017 In IDLE, x is captured on a rising edge with data_x_vld&&data_x_rdy, and y likewise with data_y_vld&&data_y_rdy; x and y are accepted independently and in either order, or on the same edge.
REQ-018 data_x_rdy is high only in IDLE while x is not yet captured; data_y_rdy likewise for y; each rdy drops on the edge after its operand is captured.
REQ-019 IDLE goes to CALC on the edge after both operands are captured.
REQ-020 CALC runs restoring division, one quotient bit per cycle, MSB first, for WIDTH+FRAC cycles on a (WIDTH+FRAC)-bit dividend x<<FRAC and a (WIDTH+1)-bit partial remainder.
REQ-021 CALC goes to DONE after the last iteration; d_out_vld asserts exactly WIDTH+FRAC cycles after entering CALC.
REQ-022 In DONE, quotient and d_out_vld are held stable until d_out_vld&&d_out_rdy; on that edge the FSM returns to IDLE and both rdys re-assert.
REQ-023 Inputs x and y are ignored outside their handshake edge.
REQ-024 Divide by zero produces an all-ones raw result, the natural restoring-division result.
REQ-025 The quotient output is registered; quotient changes only on DONE entry or reset.

Reset
REQ-026 asyn_reset forces IDLE and clears both captured flags and all datapath registers. Outputs during reset: quotient=0, d_out_vld=0, data_x_rdy=0, data_y_rdy=0.
REQ-027 After reset release, data_x_rdy and data_y_rdy go high from the first clock edge.
REQ-028 Reset asserted mid-CALC or in DONE aborts the operation immediately; no d_out_vld is produced for the aborted operation.

Configuration
REQ-029 With the macro SERIAL_DIV_SATURATE_EN defined, a result whose full (WIDTH+FRAC)-bit quotient exceeds 2^WIDTH-1, or a divide by zero, outputs all ones.
REQ-030 Without SERIAL_DIV_SATURATE_EN, quotient is the low WIDTH bits of the full quotient.

Structure
REQ-031 A shared package serial_div_pkg holds the FSM state enum (IDLE/CALC/DONE) and the default WIDTH/FRAC constants.
REQ-032 An optional sub-module serial_div_step implements one restoring iteration: remainder in, divisor in, next-bit in, remainder out, quotient bit out.

Verification
REQ-033 WIDTH=8, FRAC=0: x=100, y=7 presented together -> quotient=14, with d_out_vld 8 cycles after CALC entry.
REQ-034 x=255 accepted first, y=1 three cycles later -> data_x_rdy low while waiting; quotient=255.
REQ-035 x=5, y=0 -> quotient=255 both with and without SERIAL_DIV_SATURATE_EN.
REQ-036 FRAC=4: x=3, y=2 -> quotient=24 (1.5 in Q4.4). x=200, y=1 -> 255 with the macro, 128 without it.
REQ-037 d_out_rdy held low 5 cycles in DONE -> quotient and d_out_vld stable; both rdys re-assert one cycle after d_out_rdy rises.
REQ-038 asyn_reset pulsed at CALC cycle 3 -> outputs reset immediately; a following operation 9/3 yields 3.

Source files
------------

// File: rtl/serial_div_pkg.sv
// Shared definitions for the serial restoring divider: FSM state encoding and
// default operand/fraction widths.
package serial_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_FRAC  = 0;

endpackage

// File: rtl/serial_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it
// did not go negative and emit the corresponding quotient bit.
module serial_div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    assign shifted     = {rem_in, next_bit};
    assign divisor_ext = (WIDTH+2)'(divisor);

    // Trial subtraction; a zero divisor always "fits", giving all-ones bits.
    always_comb begin
        q_bit   = (shifted >= divisor_ext);
        rem_out = q_bit ? (WIDTH+1)'(shifted - divisor_ext) : (WIDTH+1)'(shifted);
    end

endmodule

// File: rtl/serial_div.sv
// Serial restoring divider with independent valid/ready handshakes on the
// dividend and divisor and a valid/ready result port.
// quotient = floor((x << FRAC) / y), one quotient bit per clock.
// Optional build macro SERIAL_DIV_SATURATE_EN: clamp overflowing results and
// divide-by-zero to all ones instead of returning the low WIDTH bits.
module serial_div
    import serial_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned FRAC  = DEFAULT_FRAC
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] quotient,
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             data_x_vld,
    output logic             data_x_rdy,
    input  logic             data_y_vld,
    output logic             data_y_rdy,
    output logic             d_out_vld,
    input  logic             d_out_rdy
);

    localparam int unsigned N  = WIDTH + FRAC;
    localparam int unsigned CW = $clog2(N + 1);

    state_t           state;
    state_t           state_next;

    logic             armed;
    logic             x_cap;
    logic             y_cap;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [N-1:0]     dividend;
    logic [N-1:0]     qacc;
    logic [N-1:0]     qacc_next;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [CW-1:0]    cnt;
    logic             last_step;
    logic             x_take;
    logic             y_take;
    logic [WIDTH-1:0] result;

    assign x_take    = data_x_vld && data_x_rdy;
    assign y_take    = data_y_vld && data_y_rdy;
    assign last_step = (cnt == CW'(N - 1));
    assign qacc_next = N'({qacc, q_bit});

    serial_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in   (rem),
        .divisor  (y_reg),
        .next_bit (dividend[N-1]),
        .rem_out  (rem_next),
        .q_bit    (q_bit)
    );

`ifdef SERIAL_DIV_SATURATE_EN
    assign result = ((y_reg == '0) || ((qacc_next >> WIDTH) != '0)) ? '1 : qacc_next[WIDTH-1:0];
`else
    assign result = qacc_next[WIDTH-1:0];
`endif

    // State register.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: collect both operands, iterate N times, wait for consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (x_cap && y_cap) state_next = CALC;
            CALC:    if (last_step)      state_next = DONE;
            DONE:    if (d_out_rdy)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; readies are held low until the first edge after reset.
    always_comb begin
        data_x_rdy = 1'b0;
        data_y_rdy = 1'b0;
        d_out_vld  = 1'b0;
        case (state)
            IDLE: begin
                data_x_rdy = armed && !x_cap;
                data_y_rdy = armed && !y_cap;
            end
            DONE:    d_out_vld = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, iteration datapath and registered result.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            armed    <= 1'b0;
            x_cap    <= 1'b0;
            y_cap    <= 1'b0;
            x_reg    <= '0;
            y_reg    <= '0;
            dividend <= '0;
            qacc     <= '0;
            rem      <= '0;
            cnt      <= '0;
            quotient <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (x_take) begin
                        x_reg <= x;
                        x_cap <= 1'b1;
                    end
                    if (y_take) begin
                        y_reg <= y;
                        y_cap <= 1'b1;
                    end
                    // Flags are cleared on CALC entry; the readies stay low
                    // outside IDLE, so they re-assert exactly on return.
                    if (x_cap && y_cap) begin
                        x_cap    <= 1'b0;
                        y_cap    <= 1'b0;
                        dividend <= N'(x_reg) << FRAC;
                        qacc     <= '0;
                        rem      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    rem      <= rem_next;
                    dividend <= dividend << 1;
                    qacc     <= qacc_next;
                    cnt      <= cnt + 1'b1;
                    if (last_step) begin
                        quotient <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div.sv
// Self-checking bench for serial_div: an 8.0 instance for the integer
// scenarios and an 8.4 instance for the fractional ones, with expected
// quotients queued at stimulus time and popped when the result appears.
module tb_serial_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       asyn_reset;

    logic [7:0] x0, y0, q0;
    logic       xv0, xr0, yv0, yr0, ov0, or0;

    logic [7:0] x1, y1, q1;
    logic       xv1, xr1, yv1, yr1, ov1, or1;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    logic [7:0] sb_f[$];

    serial_div #(.WIDTH(8), .FRAC(0)) dut (
        .x          (x0),
        .y          (y0),
        .quotient   (q0),
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .data_x_vld (xv0),
        .data_x_rdy (xr0),
        .data_y_vld (yv0),
        .data_y_rdy (yr0),
        .d_out_vld  (ov0),
        .d_out_rdy  (or0)
    );

    serial_div #(.WIDTH(8), .FRAC(4)) dut_f (
        .x          (x1),
        .y          (y1),
        .quotient   (q1),
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .data_x_vld (xv1),
        .data_x_rdy (xr1),
        .data_y_vld (yv1),
        .data_y_rdy (yr1),
        .d_out_vld  (ov1),
        .d_out_rdy  (or1)
    );

    // Reference: floor((a << frac) / b); zero divisor gives all ones of the full width.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input int frac);
        logic [15:0] num;
        logic [15:0] full;
        num = 16'(a) << frac;
        if (b == 8'd0) full = (16'd1 << (8 + frac)) - 16'd1;
        else           full = num / 16'(b);
`ifdef SERIAL_DIV_SATURATE_EN
        if (b == 8'd0 || full > 16'd255) return 8'hFF;
`endif
        return full[7:0];
    endfunction

    // Present an operation to the 8.0 instance; y optionally follows x by ygap cycles.
    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int ygap, input bit push);
        int n = 0;
        while (!(xr0 && yr0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (!(xr0 && yr0)) begin
            bad++;
            $display("FAIL idle_wait: x_rdy=%0b y_rdy=%0b required 1 1", xr0, yr0);
        end
        if (push) sb.push_back(model(a, b, 0));
        x0 = a; xv0 = 1'b1;
        if (ygap == 0) begin
            y0 = b; yv0 = 1'b1;
        end
        @(posedge clk); #1;
        xv0 = 1'b0; x0 = 8'($urandom);
        if (ygap == 0) begin
            yv0 = 1'b0; y0 = 8'($urandom);
        end else begin
            for (int i = 0; i < ygap; i++) begin
                total++;
                if (xr0 !== 1'b0 || yr0 !== 1'b1) begin
                    bad++;
                    $display("FAIL rdy_while_waiting: x_rdy=%0b y_rdy=%0b required 0 1", xr0, yr0);
                end
                @(posedge clk); #1;
            end
            y0 = b; yv0 = 1'b1;
            @(posedge clk); #1;
            yv0 = 1'b0; y0 = 8'($urandom);
        end
    endtask

    // Wait (bounded) for d_out_vld on the 8.0 instance and score the quotient.
    task automatic collect(output int lat);
        logic [7:0] exp;
        lat = 0;
        while (ov0 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (ov0 !== 1'b1) begin
            bad++;
            $display("FAIL out_timeout: d_out_vld=%0b required 1", ov0);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: quotient=%0d with nothing expected", q0);
        end else begin
            exp = sb.pop_front();
            if (q0 !== exp) begin
                bad++;
                $display("FAIL quotient: got %0d required %0d", q0, exp);
            end
        end
    endtask

    task automatic test_reset;
        asyn_reset = 1'b1;
        #1;
        total++;
        if (q0 !== 8'd0 || ov0 !== 1'b0 || xr0 !== 1'b0 || yr0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: q=%0d vld=%0b xr=%0b yr=%0b required 0 0 0 0", q0, ov0, xr0, yr0);
        end
        @(posedge clk); #3;
        asyn_reset = 1'b0;
        #1;
        total++;
        if (xr0 !== 1'b0 || yr0 !== 1'b0) begin
            bad++;
            $display("FAIL rdy_before_edge: xr=%0b yr=%0b required 0 0", xr0, yr0);
        end
        @(posedge clk); #1;
        total++;
        if (xr0 !== 1'b1 || yr0 !== 1'b1 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL rdy_after_edge: xr=%0b yr=%0b vld=%0b required 1 1 0", xr0, yr0, ov0);
        end
    endtask

    task automatic test_basic;
        int lat;
        or0 = 1'b1;
        send_op(8'd100, 8'd7, 0, 1'b1);
        collect(lat);
        // Capture edge, one edge into CALC, then 8 iterations.
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL latency: got %0d edges after capture required 9", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_staggered;
        int lat;
        send_op(8'd255, 8'd1, 3, 1'b1);
        collect(lat);
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        int lat;
        send_op(8'd5, 8'd0, 0, 1'b1);
        collect(lat);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat;
        logic [7:0] held;
        or0 = 1'b0;
        send_op(8'd37, 8'd5, 0, 1'b1);
        collect(lat);
        held = q0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (ov0 !== 1'b1 || q0 !== held || xr0 !== 1'b0 || yr0 !== 1'b0) begin
                bad++;
                $display("FAIL hold_done: vld=%0b q=%0d xr=%0b yr=%0b required 1 %0d 0 0", ov0, q0, xr0, yr0, held);
            end
        end
        or0 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ov0 !== 1'b0 || xr0 !== 1'b1 || yr0 !== 1'b1) begin
            bad++;
            $display("FAIL release_done: vld=%0b xr=%0b yr=%0b required 0 1 1", ov0, xr0, yr0);
        end
    endtask

    task automatic test_abort;
        int lat;
        bit seen = 1'b0;
        or0 = 1'b1;
        send_op(8'd200, 8'd3, 0, 1'b0);
        @(posedge clk); #1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 asyn_reset = 1'b1;
        #1;
        total++;
        if (q0 !== 8'd0 || ov0 !== 1'b0 || xr0 !== 1'b0 || yr0 !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs: q=%0d vld=%0b xr=%0b yr=%0b required 0 0 0 0", q0, ov0, xr0, yr0);
        end
        @(negedge clk);
        asyn_reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (ov0 === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_output: d_out_vld seen=1 required 0");
        end
        send_op(8'd9, 8'd3, 0, 1'b1);
        collect(lat);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [7:0] ta[4] = '{8'd0, 8'd255, 8'd1, 8'd128};
        logic [7:0] tb[4] = '{8'd1, 8'd255, 8'd2, 8'd255};
        logic [7:0] a, b;
        or0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                a = ta[i]; b = tb[i];
            end else begin
                a = 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            end
            send_op(a, b, int'($urandom_range(0, 2)), 1'b1);
            collect(lat);
            @(posedge clk); #1;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
    endtask

    // Full operation on the 8.4 instance with both operands on the same edge.
    task automatic frac_op(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        logic [7:0] exp;
        or1 = 1'b1;
        while (!(xr1 && yr1) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        sb_f.push_back(model(a, b, 4));
        x1 = a; y1 = b; xv1 = 1'b1; yv1 = 1'b1;
        @(posedge clk); #1;
        xv1 = 1'b0; yv1 = 1'b0; x1 = 8'($urandom); y1 = 8'($urandom);
        n = 0;
        while (ov1 !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        exp = sb_f.pop_front();
        total++;
        if (ov1 !== 1'b1) begin
            bad++;
            $display("FAIL frac_timeout: d_out_vld=%0b required 1", ov1);
        end else if (q1 !== exp) begin
            bad++;
            $display("FAIL frac_quotient: %0d/%0d got %0d required %0d", a, b, q1, exp);
        end else if (n !== 13) begin
            bad++;
            $display("FAIL frac_latency: got %0d edges after capture required 13", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_frac;
        frac_op(8'd3, 8'd2);
        frac_op(8'd200, 8'd1);
        frac_op(8'd7, 8'd0);
    endtask

    initial begin
        asyn_reset = 1'b0;
        x0 = '0; y0 = '0; xv0 = 1'b0; yv0 = 1'b0; or0 = 1'b0;
        x1 = '0; y1 = '0; xv1 = 1'b0; yv1 = 1'b0; or1 = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_staggered();
        test_div_zero();
        test_backpressure();
        test_abort();
        test_frac();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
